// File: rtl/instr_sequencer.sv
// Multi-cycle control unit: accepts one 8-bit instruction per handshake and sequences datapath strobes.
// Optional retire counter (port retire_cnt) is present only when SEQ_RETIRE_CNT_EN is defined.
// state  | meaning
// IDLE   | waiting for an instruction, instr_ready high
// EX_IN  | external input written to reg[dest]
// EX_MOV | reg[source] copied to reg[dest]
// EX_OUT | reg[source] driven to output port
// ADD_RA | reg A loaded into operand latch A
// ADD_RB | reg[source] loaded into operand latch B
// ADD_WB | sum written back to reg A
module instr_sequencer
  #(parameter int CNT_W = 16)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       instr,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic             instr_done,
   output logic             busy,
   output logic             in_sig,
   output logic             add_sig,
   output logic             mov_sig,
   output logic             out_sig,
   output logic             read_en,
   output logic             write_en,
   output logic             load_a,
   output logic             load_b,
   output logic             sum_sig,
   output logic [2:0]       source,
`ifdef SEQ_RETIRE_CNT_EN
   output logic [CNT_W-1:0] retire_cnt,
`endif
   output logic [2:0]       dest
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EX_IN  = 3'd1,
      EX_MOV = 3'd2,
      EX_OUT = 3'd3,
      ADD_RA = 3'd4,
      ADD_RB = 3'd5,
      ADD_WB = 3'd6
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic       accept;

   assign instr_ready = (state_q == IDLE) && !rst;
   assign accept      = instr_valid && instr_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ir_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               ir_d = instr;
               case (instr[7:6])
                  2'b00:   state_d = EX_IN;
                  2'b01:   state_d = ADD_RA;
                  2'b10:   state_d = EX_MOV;
                  default: state_d = EX_OUT;
               endcase
            end
         end
         ADD_RA:  state_d = ADD_RB;
         ADD_RB:  state_d = ADD_WB;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE);
      instr_done = 1'b0;
      in_sig     = 1'b0;
      add_sig    = 1'b0;
      mov_sig    = 1'b0;
      out_sig    = 1'b0;
      read_en    = 1'b0;
      write_en   = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      sum_sig    = 1'b0;
      source     = 3'd0;
      dest       = 3'd0;
      case (state_q)
         EX_IN: begin
            in_sig     = 1'b1;
            write_en   = 1'b1;
            dest       = ir_q[5:3];
            instr_done = 1'b1;
         end
         EX_MOV: begin
            mov_sig    = 1'b1;
            read_en    = 1'b1;
            source     = ir_q[2:0];
            write_en   = 1'b1;
            dest       = ir_q[5:3];
            instr_done = 1'b1;
         end
         EX_OUT: begin
            out_sig    = 1'b1;
            read_en    = 1'b1;
            source     = ir_q[2:0];
            instr_done = 1'b1;
         end
         ADD_RA: begin
            add_sig = 1'b1;
            read_en = 1'b1;
            load_a  = 1'b1;
         end
         ADD_RB: begin
            add_sig = 1'b1;
            read_en = 1'b1;
            source  = ir_q[2:0];
            load_b  = 1'b1;
         end
         ADD_WB: begin
            add_sig    = 1'b1;
            sum_sig    = 1'b1;
            write_en   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef SEQ_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (instr_done)
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: small datapath driven by the DUT strobes, instruction-level reference model,
// per-cycle strobe comparison, directed literal checks and a randomized phase with occasional resets.
module tb_instr_sequencer;

  localparam int CNT_W = 4;
`ifdef SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       instr_valid = 1'b0;
  logic       instr_ready, instr_done, busy;
  logic       in_sig, add_sig, mov_sig, out_sig;
  logic       read_en, write_en, load_a, load_b, sum_sig;
  logic [2:0] source, dest;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] in_val = 8'h00;
  logic [7:0] dp [8] = '{default: 8'h00};
  logic [7:0] la = 8'h00, lb = 8'h00;
  logic [7:0] bus;

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_done  (instr_done),
    .busy        (busy),
    .in_sig      (in_sig),
    .add_sig     (add_sig),
    .mov_sig     (mov_sig),
    .out_sig     (out_sig),
    .read_en     (read_en),
    .write_en    (write_en),
    .load_a      (load_a),
    .load_b      (load_b),
    .sum_sig     (sum_sig),
    .source      (source),
`ifdef SEQ_RETIRE_CNT_EN
    .retire_cnt  (retire_cnt),
`endif
    .dest        (dest)
  );

  always #5 clk = ~clk;

  // Environment datapath: register file, operand latches and the shared bus.
  always_comb begin
    bus = 8'h00;
    if (in_sig)       bus = in_val;
    else if (read_en) bus = dp[source];
    else if (sum_sig) bus = la + lb;
  end

  always @(posedge clk) begin
    if (write_en) dp[dest] <= bus;
    if (load_a)   la <= bus;
    if (load_b)   lb <= bus;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk(input bit rdy, input bit bsy, input bit dn, input bit i,
                                     input bit a, input bit m, input bit o, input bit rd,
                                     input bit wr, input bit lda, input bit ldb, input bit sm,
                                     input logic [2:0] s, input logic [2:0] d);
    return {rdy, bsy, dn, i, a, m, o, rd, wr, lda, ldb, sm, s, d};
  endfunction

  function automatic logic [17:0] dutv();
    return mk(instr_ready, busy, instr_done, in_sig, add_sig, mov_sig, out_sig,
              read_en, write_en, load_a, load_b, sum_sig, source, dest);
  endfunction

  localparam logic [17:0] IDLE_V = {1'b1, 17'd0};

  typedef struct {
    logic [17:0] v;
    logic [7:0]  ins;
    bit          last;
  } step_t;

  step_t      q[$];
  logic [7:0] m [8] = '{default: 8'h00};
  bit         acc_prev = 1'b0;
  logic [7:0] ins_prev = 8'h00;
  int         cnt_m = 0;

  // Expected micro-steps of one instruction, straight from the opcode table.
  task automatic push_instr(input logic [7:0] ins);
    case (ins[7:6])
      2'd0: q.push_back('{mk(0,1,1,1,0,0,0,0,1,0,0,0, 3'd0, ins[5:3]), ins, 1'b1});
      2'd1: begin
        q.push_back('{mk(0,1,0,0,1,0,0,1,0,1,0,0, 3'd0, 3'd0), ins, 1'b0});
        q.push_back('{mk(0,1,0,0,1,0,0,1,0,0,1,0, ins[2:0], 3'd0), ins, 1'b0});
        q.push_back('{mk(0,1,1,0,1,0,0,0,1,0,0,1, 3'd0, 3'd0), ins, 1'b1});
      end
      2'd2: q.push_back('{mk(0,1,1,0,0,1,0,1,1,0,0,0, ins[2:0], ins[5:3]), ins, 1'b1});
      default: q.push_back('{mk(0,1,1,0,0,0,1,1,0,0,0,0, ins[2:0], 3'd0), ins, 1'b1});
    endcase
  endtask

  always @(negedge clk) begin
    step_t       s;
    logic [17:0] ev;
    logic [7:0]  ins;
    bit          last;
    if (rst) begin
      chk("reset_outputs", 64'(dutv()), 64'd0);
`ifdef SEQ_RETIRE_CNT_EN
      chk("reset_retire_cnt", 64'(retire_cnt), 64'd0);
`endif
      q.delete();
      acc_prev = 1'b0;
      cnt_m    = 0;
    end else begin
      if (acc_prev) push_instr(ins_prev);
      if (q.size() > 0) begin
        s = q.pop_front();
        ev = s.v; ins = s.ins; last = s.last;
      end else begin
        ev = IDLE_V; ins = 8'h00; last = 1'b0;
      end
      chk("strobes", 64'(dutv()), 64'(ev));
      chk("bus_exclusive", 64'((int'(in_sig) + int'(read_en) + int'(sum_sig)) <= 1), 64'd1);
`ifdef SEQ_RETIRE_CNT_EN
      chk("retire_cnt", 64'(retire_cnt), 64'(cnt_m % (1 << CNT_W)));
`endif
      if (last && ins[7:6] == 2'd3) chk("out_bus", 64'(bus), 64'(m[ins[2:0]]));
      if (last) begin
        case (ins[7:6])
          2'd0: m[ins[5:3]] = in_val;
          2'd1: m[0] = m[0] + m[ins[2:0]];
          2'd2: m[ins[5:3]] = m[ins[2:0]];
          default: ;
        endcase
        cnt_m++;
      end
      if (ev == IDLE_V && q.size() == 0)
        for (int k = 0; k < 8; k++) chk("regfile", 64'(dp[k]), 64'(m[k]));
      acc_prev = instr_valid && instr_ready;
      ins_prev = instr;
    end
  end

  // Callers sit just after a rising edge; in_val is changed only once the previous instruction is over.
  task automatic send(input logic [7:0] ins, input logic [7:0] iv);
    int n = 0;
    instr = ins;
    instr_valid = 1'b1;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 64'd1, 64'd0);
    in_val = iv;
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2;
    chk("rst_ready_low", 64'(instr_ready), 64'd0);
    chk("rst_busy_low", 64'(busy), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(instr_ready), 64'd1);

    for (int i = 0; i < 8; i++) send({2'b00, 3'(i), 3'b000}, 8'(20 + 10 * i));
    wait_idle();
    chk("in_load_a", 64'(dp[0]), 64'd20);
    chk("in_load_h", 64'(dp[7]), 64'd90);

    send(8'b01000001, 8'h00); wait_idle();
    chk("add_a_b", 64'(dp[0]), 64'd50);
    send(8'b01011000, 8'h00); wait_idle();
    chk("add_a_a", 64'(dp[0]), 64'd100);
    send(8'b00000000, 8'd200);
    send(8'b01000000, 8'h00); wait_idle();
    chk("add_wrap", 64'(dp[0]), 64'd144);

    send(8'b10001111, 8'h00); wait_idle();
    chk("mov_h_to_b", 64'(dp[1]), 64'd90);
    send(8'b11001001, 8'h00);
    @(negedge clk);
    chk("out_sig", 64'(out_sig), 64'd1);
    chk("out_literal_bus", 64'(bus), 64'd90);
    @(posedge clk); #1;
    wait_idle();

    // Abort an ADD while in its second read step.
    send(8'b01000010, 8'h00);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("abort_strobes", 64'({add_sig, read_en, load_b, busy, instr_ready}), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_a_kept", 64'(dp[0]), 64'd144);

`ifdef SEQ_RETIRE_CNT_EN
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send(8'b11000000, 8'h00);
    wait_idle();
    chk("retire_wrap", 64'(retire_cnt), 64'd1);
`endif

    repeat (800) begin
      @(posedge clk); #1;
      instr_valid = ($urandom_range(0, 3) != 0);
      instr       = 8'($urandom);
      in_val      = 8'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
      end
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    wait_idle();
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
